// File: rtl/probe_pkg.sv
// Shared types for the fetch-stage probe trace buffer: FSM state encoding
// and the layout of one captured trace entry.
package probe_pkg;

    localparam int TRACE_DWIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_DWIDTH-1:0] pc;
        logic [TRACE_DWIDTH-1:0] insn;
    } trace_entry_t;

endpackage

// File: rtl/probe_trace_mem.sv
// Trace storage: DEPTH entries of {pc, insn}, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module probe_trace_mem #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [2*DWIDTH-1:0]   wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [2*DWIDTH-1:0]   rd_data
);

    logic [2*DWIDTH-1:0] mem [DEPTH];

    // Write one entry per enabled cycle; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/probe_trace_buffer.sv
// Fetch-stage trace buffer: once armed it records {pc, insn} samples into a
// circular buffer, stops a programmable number of samples after a PC match,
// then drains oldest-first through a valid/ready readout port.
module probe_trace_buffer
    import probe_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int CWIDTH = $clog2(DEPTH+1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic [DWIDTH-1:0] trig_pc_i,
    input  logic [CWIDTH-1:0] post_cnt_i,
    input  logic              smp_valid_i,
    input  logic [DWIDTH-1:0] smp_pc_i,
    input  logic [DWIDTH-1:0] smp_insn_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DWIDTH-1:0] rd_pc_o,
    output logic [DWIDTH-1:0] rd_insn_o,
    output logic [1:0]        state_o,
    output logic [CWIDTH-1:0] count_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CWIDTH-1:0] COUNT_FULL = CWIDTH'(DEPTH);
    localparam logic [CWIDTH-1:0] COUNT_ONE  = CWIDTH'(1);

    trace_state_e        state;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CWIDTH-1:0]   count;
    logic [CWIDTH-1:0]   remaining;
    logic [CWIDTH-1:0]   post_cnt_q;
    logic                overflow;
    logic                rd_valid;
    logic                capturing;
    logic                wr_en;
    logic                trig_hit;
    logic                rd_fire;
    logic [2*DWIDTH-1:0] rd_data;

    assign capturing = (state == ST_ARMED) || (state == ST_POST);
    assign wr_en     = capturing && smp_valid_i && !arm_i;
    assign trig_hit  = wr_en && (state == ST_ARMED) && (smp_pc_i == trig_pc_i);
    assign rd_fire   = rd_valid && rd_ready_i;

    // With count entries held and wr_ptr past the newest, the oldest sits
    // count slots behind; a full buffer wraps back to wr_ptr itself.
    assign rd_ptr = wr_ptr - count[AW-1:0];

    probe_trace_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({smp_pc_i, smp_insn_i}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Capture/trigger/readout FSM with arm taking priority in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            count      <= '0;
            remaining  <= '0;
            post_cnt_q <= '0;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
        end else if (arm_i) begin
            state      <= ST_ARMED;
            wr_ptr     <= '0;
            count      <= '0;
            remaining  <= '0;
            post_cnt_q <= post_cnt_i;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count == COUNT_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + COUNT_ONE;
                end
            end
            case (state)
                ST_ARMED: begin
                    if (trig_hit) begin
                        if (post_cnt_q != '0) begin
                            state     <= ST_POST;
                            remaining <= post_cnt_q;
                        end else begin
                            state    <= ST_DONE;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (wr_en) begin
                        remaining <= remaining - COUNT_ONE;
                        if (remaining == COUNT_ONE) begin
                            state    <= ST_DONE;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_fire) begin
                        count <= count - COUNT_ONE;
                        if (count == COUNT_ONE) begin
                            state    <= ST_IDLE;
                            rd_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_valid_o = rd_valid;
    assign rd_pc_o    = rd_data[2*DWIDTH-1:DWIDTH];
    assign rd_insn_o  = rd_data[DWIDTH-1:0];
    assign state_o    = state;
    assign count_o    = count;
    assign overflow_o = overflow;

endmodule
